cvmcu_dbg_req_arb: RTL and testbench
====================================

CVMCU_DBG_REQ_ARB -- requirements
Module: cvmcu_dbg_req_arb

Interface
REQ-001 Parameter NUM_REQ, default 3, number of debug requesters (index 0 = debug module, 1 = external pin, 2 = software); legal range 2..8.
REQ-002 Parameter TIMEOUT_CYC, default 1024, number of cycles allowed from debug request to core-halted acknowledge; legal range 2..65535.
REQ-003 Port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 Port reset  input  1  reset, synchronous and active-high.
REQ-005 Port req_i  input  NUM_REQ  level-sensitive halt request, one bit per requester.
REQ-006 Port stoptimer_en_i  input  1  configuration bit: when 1, stoptimer_o is asserted while the core is held in debug.
REQ-007 Port core_halted_i  input  1  core status: 1 while the core is in debug mode.
REQ-008 Port debug_req_o  input-to-core  1  debug request to the core (drives the core debug_req_i); direction is output.
REQ-009 Port stoptimer_o  output  1  timer-stop indication to the system.
REQ-010 Port grant_o  output  NUM_REQ  one-hot owner of the debug session; all-zero when no owner.
REQ-011 Port timeout_o  output  1  single-cycle pulse on an acknowledge timeout.
REQ-012 Port busy_o  output  1  1 whenever the FSM is not in IDLE.

Function
REQ-013 The FSM SHALL have exactly four states: IDLE, REQ, HALTED, RELEASE.
REQ-014 IDLE: when any req_i bit is 1, the FSM SHALL select one owner by round-robin and go to REQ on the next edge; grant_o SHALL be registered and valid from the first REQ cycle.
REQ-015 Round-robin: the search SHALL start at the index after the last owner, and wrap from NUM_REQ-1 to 0; after reset the search SHALL start at index 0.
REQ-016 REQ: debug_req_o SHALL be 1; a cycle counter SHALL clear on REQ entry and increment by 1 each REQ cycle.
REQ-017 REQ to HALTED when core_halted_i=1; this takes priority over owner drop and over timeout in the same cycle.
REQ-018 REQ to IDLE when the owner's req_i bit is 0 and core_halted_i=0 (abort); timeout_o SHALL NOT pulse.
REQ-019 REQ to IDLE when the counter equals TIMEOUT_CYC-1 with core_halted_i=0.
REQ-020 In the REQ-to-IDLE timeout case, timeout_o SHALL pulse for exactly 1 cycle, coincident with the first IDLE cycle.
REQ-021 HALTED: debug_req_o SHALL be 0, and stoptimer_o SHALL equal the live value of stoptimer_en_i.
REQ-022 HALTED: the FSM SHALL stay in HALTED while the owner's req_i bit is 1, and go to RELEASE when it is 0.
REQ-023 HALTED: requests from non-owners SHALL be ignored, with no preemption.
REQ-024 RELEASE: debug_req_o SHALL be 0 and stoptimer_o SHALL equal stoptimer_en_i; the FSM SHALL go to IDLE when core_halted_i=0.
REQ-025 RELEASE: if the owner re-asserts req_i while in RELEASE, the FSM SHALL still complete the transition to IDLE and re-arbitrate there.
REQ-026 If core_halted_i falls while in HALTED (the core resumed on its own), the FSM SHALL go directly to IDLE.
REQ-027 IDLE: debug_req_o=0, stoptimer_o=0, grant_o=0, busy_o=0.
REQ-028 The owner pointer SHALL update only on IDLE exit; the counter width SHALL be $clog2(TIMEOUT_CYC+1) and the counter SHALL never wrap.
REQ-029 All outputs SHALL be registered; there SHALL be no combinational path from any input to debug_req_o, grant_o or timeout_o.

Reset
REQ-030 While reset=1 at a clock edge: state=IDLE, counter=0, round-robin pointer such that the next search starts at 0, all outputs 0.
REQ-031 Reset asserted mid-session (any state) SHALL abort the session on that edge with no timeout pulse; debug_req_o and stoptimer_o SHALL be 0 in the following cycle.
REQ-032 The first arbitration SHALL occur on the first edge after reset deasserts.

Verification
REQ-033 Basic session: req_i=001; core_halted_i rises 5 cycles after debug_req_o; stoptimer_en_i=1 -> grant_o=001; debug_req_o high 5 cycles then 0; stoptimer_o=1 through HALTED and RELEASE; req_i=000 then core_halted_i=0 -> IDLE, all outputs 0.
REQ-034 Timeout: TIMEOUT_CYC=8, req_i=010, core_halted_i held 0 -> debug_req_o high exactly 8 cycles; timeout_o 1-cycle pulse; grant_o=000; busy_o=0.
REQ-035 Round-robin: req_i=111 held, 3 complete sessions -> grant_o sequence 001, 010, 100; a fourth session grants 001 again.
REQ-036 Abort and simultaneous events: owner drops req_i in REQ -> IDLE, no timeout pulse; core_halted_i rises in the same cycle as owner drop -> HALTED, then RELEASE.
REQ-037 Reset in HALTED with stoptimer_o=1: reset pulse -> next cycle debug_req_o=0, stoptimer_o=0, grant_o=0, and the next grant goes to index 0.
REQ-038 stoptimer_en_i=0 session -> stoptimer_o stays 0 through the whole session; stoptimer_en_i toggled while in HALTED -> stoptimer_o follows with 1-cycle latency.

Source files
------------

// File: rtl/cvmcu_dbg_req_arb.sv
`default_nettype none
// ============================================================================
// Module   : cvmcu_dbg_req_arb
// Purpose  : Round-robin arbiter that owns one debug-halt session with the core.
// Revision : 1.0 - initial release
// ============================================================================
module cvmcu_dbg_req_arb #(
  parameter int unsigned NUM_REQ     = 3,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               stoptimer_en_i,
  input  logic               core_halted_i,
  output logic               debug_req_o,
  output logic               stoptimer_o,
  output logic [NUM_REQ-1:0] grant_o,
  output logic               timeout_o,
  output logic               busy_o
);

  localparam int unsigned   PW       = $clog2(NUM_REQ);
  localparam int unsigned   CW       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [PW:0]   NREQ_W   = (PW + 1)'(NUM_REQ);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_HALTED  = 2'd2,
    ST_RELEASE = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               timeout_d;
  logic               debug_req_q, stoptimer_q, timeout_q, busy_q;

  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  logic                 pick_vld;
  logic [PW-1:0]        pick_off, pick_idx, nxt_ptr;
  logic [PW:0]          sum_idx, sum_nxt;
  logic                 own_req;

  // Rotate so bit 0 is the first index to search (ptr_q always holds last owner + 1).
  assign req_dbl = {req_i, req_i};
  assign req_rot = NUM_REQ'(req_dbl >> ptr_q);
  assign own_req = |(req_i & grant_q);

  always_comb begin
    pick_vld = 1'b0;
    pick_off = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!pick_vld && req_rot[i]) begin
        pick_vld = 1'b1;
        pick_off = PW'(i);
      end
    end
    sum_idx = {1'b0, ptr_q} + {1'b0, pick_off};
    if (sum_idx >= NREQ_W) begin
      sum_idx = sum_idx - NREQ_W;
    end
    pick_idx = sum_idx[PW-1:0];
    sum_nxt  = {1'b0, pick_idx} + {{PW{1'b0}}, 1'b1};
    if (sum_nxt >= NREQ_W) begin
      sum_nxt = '0;
    end
    nxt_ptr = sum_nxt[PW-1:0];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    timeout_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        grant_d = '0;
        if (pick_vld) begin
          state_d = ST_REQ;
          cnt_d   = '0;
          ptr_d   = nxt_ptr;
          grant_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
        end
      end
      ST_REQ: begin
        // Halt acknowledge beats an owner drop, which in turn beats the timeout.
        if (core_halted_i) begin
          state_d = ST_HALTED;
        end else if (!own_req) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = ST_IDLE;
          timeout_d = 1'b1;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_HALTED: begin
        if (!core_halted_i) begin
          state_d = ST_IDLE;
        end else if (!own_req) begin
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (!core_halted_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_d == ST_IDLE) begin
      grant_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      grant_q     <= '0;
      debug_req_q <= 1'b0;
      stoptimer_q <= 1'b0;
      timeout_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      grant_q     <= grant_d;
      debug_req_q <= (state_d == ST_REQ);
      stoptimer_q <= ((state_d == ST_HALTED) || (state_d == ST_RELEASE)) && stoptimer_en_i;
      timeout_q   <= timeout_d;
      busy_q      <= (state_d != ST_IDLE);
    end
  end

  assign debug_req_o = debug_req_q;
  assign stoptimer_o = stoptimer_q;
  assign grant_o     = grant_q;
  assign timeout_o   = timeout_q;
  assign busy_o      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_cvmcu_dbg_req_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_cvmcu_dbg_req_arb
// Purpose  : Directed and random checks of cvmcu_dbg_req_arb against a session model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cvmcu_dbg_req_arb;

  localparam int N = 3;
  localparam int T = 8;

  logic         clk;
  logic         rst;
  logic [N-1:0] req;
  logic         en;
  logic         halted;
  logic         debug_req_o, stoptimer_o, timeout_o, busy_o;
  logic [N-1:0] grant_o;

  int total = 0;
  int bad   = 0;

  // Session model: mode 0 idle, 1 requesting, 2 halted, 3 releasing.
  int   m_mode  = 0;
  int   m_owner = 0;
  int   m_last  = N - 1;
  int   m_wait  = 0;
  logic e_to    = 1'b0;
  logic e_st    = 1'b0;

  cvmcu_dbg_req_arb #(.NUM_REQ(N), .TIMEOUT_CYC(T)) dut (
    .clk           (clk),
    .reset         (rst),
    .req_i         (req),
    .stoptimer_en_i(en),
    .core_halted_i (halted),
    .debug_req_o   (debug_req_o),
    .stoptimer_o   (stoptimer_o),
    .grant_o       (grant_o),
    .timeout_o     (timeout_o),
    .busy_o        (busy_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit found;
    e_to = 1'b0;
    if (rst) begin
      m_mode = 0;
      m_last = N - 1;
      m_wait = 0;
      e_st   = 1'b0;
    end else begin
      case (m_mode)
        0: if (req != 0) begin
          found = 0;
          for (int k = 1; k <= N; k++) begin
            if (!found && req[(m_last + k) % N]) begin
              m_owner = (m_last + k) % N;
              found   = 1;
            end
          end
          m_last = m_owner;
          m_mode = 1;
          m_wait = 0;
        end
        1: begin
          if (halted)                m_mode = 2;
          else if (!req[m_owner])    m_mode = 0;
          else if (m_wait == T - 1) begin m_mode = 0; e_to = 1'b1; end
          else                       m_wait++;
        end
        2: begin
          if (!halted)            m_mode = 0;
          else if (!req[m_owner]) m_mode = 3;
        end
        default: if (!halted) m_mode = 0;
      endcase
      e_st = (m_mode >= 2) && en;
    end
  endtask

  task automatic tick();
    logic [N-1:0] e_grant;
    @(posedge clk);
    model_edge();
    #1;
    e_grant = (m_mode != 0) ? N'(1 << m_owner) : '0;
    chk("debug_req", debug_req_o, (m_mode == 1));
    chk("busy", busy_o, (m_mode != 0));
    chk("grant", grant_o, e_grant);
    chk("stoptimer", stoptimer_o, e_st);
    chk("timeout", timeout_o, e_to);
  endtask

  task automatic session(output logic [N-1:0] g);
    int i;
    i = 0;
    while (!debug_req_o && i < 10) begin tick(); i++; end
    chk("rr_reached_req", debug_req_o, 1);
    g = grant_o;
    halted = 1'b1; tick();
    req = 3'b111 & ~g; tick();
    halted = 1'b0; tick();
    req = 3'b111;
  endtask

  initial begin
    int n;
    int i;
    logic [N-1:0] g;
    logic [N-1:0] rr_exp [4];
    rr_exp[0] = 3'b001; rr_exp[1] = 3'b010; rr_exp[2] = 3'b100; rr_exp[3] = 3'b001;

    rst = 1'b1; req = '0; en = 1'b0; halted = 1'b0;
    tick(); tick();
    chk("reset_grant", grant_o, 0);
    chk("reset_busy", busy_o, 0);
    rst = 1'b0;

    // Basic session with halt acknowledge after five request cycles.
    req = 3'b001; en = 1'b1;
    i = 0;
    while (!debug_req_o && i < 10) begin tick(); i++; end
    n = debug_req_o ? 1 : 0;
    repeat (4) begin tick(); n += debug_req_o ? 1 : 0; end
    halted = 1'b1; tick(); n += debug_req_o ? 1 : 0;
    chk("basic_dbg_cycles", n, 5);
    chk("basic_grant", grant_o, 3'b001);
    chk("basic_stop_halted", stoptimer_o, 1);
    req = '0; tick();
    chk("basic_stop_release", stoptimer_o, 1);
    halted = 1'b0; tick();
    chk("basic_idle_busy", busy_o, 0);
    chk("basic_idle_stop", stoptimer_o, 0);

    // Acknowledge timeout.
    req = 3'b010; n = 0; i = 0;
    while (!timeout_o && i < 20) begin tick(); n += debug_req_o ? 1 : 0; i++; end
    chk("to_dbg_cycles", n, T);
    chk("to_pulse", timeout_o, 1);
    chk("to_grant", grant_o, 0);
    chk("to_busy", busy_o, 0);
    req = '0; tick();
    chk("to_single", timeout_o, 0);

    // Round robin over four sessions from a fresh reset.
    rst = 1'b1; tick(); rst = 1'b0; en = 1'b0;
    req = 3'b111;
    for (int s = 0; s < 4; s++) begin
      session(g);
      chk("rr_grant", g, rr_exp[s]);
    end
    req = '0; tick();

    // Abort by owner drop, then drop coincident with halt.
    req = 3'b001; tick(); tick();
    req = '0; tick();
    chk("abort_busy", busy_o, 0);
    chk("abort_no_to", timeout_o, 0);
    req = 3'b001; tick(); tick();
    req = '0; halted = 1'b1; tick();
    chk("sim_busy", busy_o, 1);
    chk("sim_dbg", debug_req_o, 0);
    tick();
    halted = 1'b0; tick();
    chk("sim_idle", busy_o, 0);

    // Reset while halted, then pointer restart and stoptimer tracking.
    en = 1'b1; req = 3'b001; tick();
    halted = 1'b1; tick();
    chk("rh_stop", stoptimer_o, 1);
    rst = 1'b1; tick();
    chk("rh_dbg", debug_req_o, 0);
    chk("rh_stop0", stoptimer_o, 0);
    chk("rh_grant", grant_o, 0);
    rst = 1'b0; halted = 1'b0; req = 3'b111; tick();
    chk("rh_next_grant", grant_o, 3'b001);
    halted = 1'b1; tick();
    en = 1'b0; tick();
    chk("st_follow0", stoptimer_o, 0);
    en = 1'b1; tick();
    chk("st_follow1", stoptimer_o, 1);
    req = '0; halted = 1'b0; tick();

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(3) == 0) req = N'($urandom);
      if ($urandom_range(4) == 0) halted = ~halted;
      if ($urandom_range(7) == 0) en = ~en;
      rst = ($urandom_range(99) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
